// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register driving the ROM address, plus the IF/ID pipeline register.
// Latency: ROM data at rom_addrs is captured into IF/ID on the next advancing edge; a redirect costs one bubble.
// Backpressure: pc_enable=0 or pc_enable_hbu=0 freezes PC, IF/ID and counters; branch_taken is ignored while stalled.
//
// Ports:
//   p_clk, p_rst_s        clock, synchronous active-high reset
//   pc_enable             global run enable
//   pc_enable_hbu         hazard unit enable (0 = stall)
//   branch_taken          ID resolved the IF/ID instruction as a taken branch/jump
//   branch_target         redirect address from ID (low 2 bits dropped)
//   rom_addrs             PC, straight from the register, to the instruction ROM
//   instruction           combinational ROM read data for rom_addrs
//   if_id_instr/pc4/valid IF/ID pipeline register
//   fetch_cnt, flush_cnt  saturating debug counters (valid loads, redirects)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             p_clk,
  input  logic             p_rst_s,
  input  logic             pc_enable,
  input  logic             pc_enable_hbu,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      rom_addrs,
  input  logic [31:0]      instruction,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        adv;
  logic        redirect;

  assign adv      = pc_enable & pc_enable_hbu;
  // A bubble in IF/ID has no branch to resolve, and a stalled ID has
  // unresolved operands, so both gate off the redirect.
  assign redirect = adv & branch_taken & if_id_valid;
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0x0.
  assign pc_plus4 = pc_q + 32'd4;

  assign rom_addrs = pc_q;

  always_ff @(posedge p_clk) begin
    if (p_rst_s) begin
      pc_q        <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      fetch_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (redirect) begin
      // Squash the wrong-path fetch currently at rom_addrs.
      pc_q        <= {branch_target[31:2], 2'b00};
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      if (flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end else if (adv) begin
      pc_q        <= pc_plus4;
      if_id_instr <= instruction;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
      if (fetch_cnt != CNT_MAX) begin
        fetch_cnt <= fetch_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        p_clk = 1'b0;
  logic        p_rst_s;
  logic        pc_enable;
  logic        pc_enable_hbu;
  logic        branch_taken;
  logic [31:0] branch_target;

  // Instance A: defaults. Instance B: RESET_PC at top of address space.
  // Instance C: 3-bit counters so saturation is reachable.
  logic [31:0] rom_a, ins_a, iid_a, pc4_a;
  logic [31:0] rom_b, ins_b, iid_b, pc4_b;
  logic [31:0] rom_c, ins_c, iid_c, pc4_c;
  logic        vld_a, vld_b, vld_c;
  logic [15:0] fcnt_a, fl_a, fcnt_b, fl_b;
  logic [2:0]  fcnt_c, fl_c;

  assign ins_a = 32'hA000_0000 | rom_a;
  assign ins_b = 32'hA000_0000 | rom_b;
  assign ins_c = 32'hA000_0000 | rom_c;

  always #5 p_clk = ~p_clk;

  if_fetch_stage dut_a (
    .p_clk(p_clk), .p_rst_s(p_rst_s), .pc_enable(pc_enable), .pc_enable_hbu(pc_enable_hbu),
    .branch_taken(branch_taken), .branch_target(branch_target), .rom_addrs(rom_a),
    .instruction(ins_a), .if_id_instr(iid_a), .if_id_pc4(pc4_a), .if_id_valid(vld_a),
    .fetch_cnt(fcnt_a), .flush_cnt(fl_a));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .p_clk(p_clk), .p_rst_s(p_rst_s), .pc_enable(pc_enable), .pc_enable_hbu(pc_enable_hbu),
    .branch_taken(branch_taken), .branch_target(branch_target), .rom_addrs(rom_b),
    .instruction(ins_b), .if_id_instr(iid_b), .if_id_pc4(pc4_b), .if_id_valid(vld_b),
    .fetch_cnt(fcnt_b), .flush_cnt(fl_b));

  if_fetch_stage #(.CNT_W(3)) dut_c (
    .p_clk(p_clk), .p_rst_s(p_rst_s), .pc_enable(pc_enable), .pc_enable_hbu(pc_enable_hbu),
    .branch_taken(branch_taken), .branch_target(branch_target), .rom_addrs(rom_c),
    .instruction(ins_c), .if_id_instr(iid_c), .if_id_pc4(pc4_c), .if_id_valid(vld_c),
    .fetch_cnt(fcnt_c), .flush_cnt(fl_c));

  int tests  = 0;
  int failed = 0;

  // Reference model: one entry per instance.
  logic [31:0] m_pc[3];
  logic [31:0] m_instr[3];
  logic [31:0] m_pc4[3];
  logic        m_valid[3];
  int          m_fetch[3];
  int          m_flush[3];
  logic [31:0] m_rst_pc[3];
  int          m_cmax[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic adv;
    adv = pc_enable & pc_enable_hbu;
    for (int i = 0; i < 3; i++) begin
      if (p_rst_s) begin
        m_pc[i] = m_rst_pc[i]; m_instr[i] = 32'h0; m_pc4[i] = 32'h0;
        m_valid[i] = 1'b0; m_fetch[i] = 0; m_flush[i] = 0;
      end else if (adv && branch_taken && m_valid[i]) begin
        m_pc[i] = branch_target & 32'hFFFF_FFFC;
        m_instr[i] = 32'h0; m_pc4[i] = 32'h0; m_valid[i] = 1'b0;
        m_flush[i] = sat_inc(m_flush[i], m_cmax[i]);
      end else if (adv) begin
        m_instr[i] = 32'hA000_0000 | m_pc[i];
        m_pc[i]    = m_pc[i] + 32'd4;
        m_pc4[i]   = m_pc[i];
        m_valid[i] = 1'b1;
        m_fetch[i] = sat_inc(m_fetch[i], m_cmax[i]);
      end
    end
  endtask

  task automatic check_all();
    chk("a_rom",   rom_a, m_pc[0]);   chk("a_instr", iid_a, m_instr[0]);
    chk("a_pc4",   pc4_a, m_pc4[0]);  chk("a_valid", {31'b0, vld_a}, {31'b0, m_valid[0]});
    chk("a_fetch", {16'b0, fcnt_a}, m_fetch[0]); chk("a_flush", {16'b0, fl_a}, m_flush[0]);
    chk("b_rom",   rom_b, m_pc[1]);   chk("b_instr", iid_b, m_instr[1]);
    chk("b_pc4",   pc4_b, m_pc4[1]);  chk("b_valid", {31'b0, vld_b}, {31'b0, m_valid[1]});
    chk("b_fetch", {16'b0, fcnt_b}, m_fetch[1]); chk("b_flush", {16'b0, fl_b}, m_flush[1]);
    chk("c_rom",   rom_c, m_pc[2]);   chk("c_instr", iid_c, m_instr[2]);
    chk("c_pc4",   pc4_c, m_pc4[2]);  chk("c_valid", {31'b0, vld_c}, {31'b0, m_valid[2]});
    chk("c_fetch", {29'b0, fcnt_c}, m_fetch[2]); chk("c_flush", {29'b0, fl_c}, m_flush[2]);
  endtask

  // Inputs are changed 1 time unit after an edge; outputs sampled there too.
  task automatic tick();
    model_edge();
    @(posedge p_clk);
    #1;
    check_all();
  endtask

  initial begin
    m_rst_pc[0] = 32'h0; m_rst_pc[1] = 32'hFFFF_FFFC; m_rst_pc[2] = 32'h0;
    m_cmax[0] = 65535;   m_cmax[1] = 65535;           m_cmax[2] = 7;
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = 32'h0; m_instr[i] = 32'h0; m_pc4[i] = 32'h0;
      m_valid[i] = 1'b0; m_fetch[i] = 0; m_flush[i] = 0;
    end

    p_rst_s = 1'b1; pc_enable = 1'b1; pc_enable_hbu = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    #1;

    // 1. Reset then run.
    tick(); tick();
    chk("rst_rom", rom_a, 32'h0);  chk("rst_instr", iid_a, 32'h0);
    chk("rst_valid", {31'b0, vld_a}, 32'h0); chk("rst_fetch", {16'b0, fcnt_a}, 32'h0);
    chk("rst_b_rom", rom_b, 32'hFFFF_FFFC);
    p_rst_s = 1'b0;
    tick();
    chk("run1_rom", rom_a, 32'h4); chk("run1_instr", iid_a, 32'hA000_0000);
    chk("run1_pc4", pc4_a, 32'h4); chk("run1_valid", {31'b0, vld_a}, 32'h1);
    chk("run1_fetch", {16'b0, fcnt_a}, 32'h1);
    // 5b. Wrap from 0xFFFF_FFFC.
    chk("wrap_rom", rom_b, 32'h0); chk("wrap_pc4", pc4_b, 32'h0);
    chk("wrap_instr", iid_b, 32'hFFFF_FFFC);
    tick();
    chk("run2_rom", rom_a, 32'h8);

    // 2. Stall two edges at 0x8.
    pc_enable_hbu = 1'b0;
    tick(); tick();
    chk("stall_rom", rom_a, 32'h8); chk("stall_instr", iid_a, 32'hA000_0004);
    chk("stall_pc4", pc4_a, 32'h8); chk("stall_fetch", {16'b0, fcnt_a}, 32'h2);
    pc_enable_hbu = 1'b1;
    tick();
    chk("resume_rom", rom_a, 32'hC);
    tick();
    chk("pre_br_pc4", pc4_a, 32'h10);

    // 3. Taken branch to 0x40; branch_taken left high over the bubble.
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("br_rom", rom_a, 32'h40); chk("br_valid", {31'b0, vld_a}, 32'h0);
    chk("br_instr", iid_a, 32'h0); chk("br_flush", {16'b0, fl_a}, 32'h1);
    tick();
    chk("br_next_instr", iid_a, 32'hA000_0040); chk("br_next_pc4", pc4_a, 32'h44);
    chk("br_bubble_flush", {16'b0, fl_a}, 32'h1);

    // 4. Branch during stall is ignored, then taken on release.
    branch_target = 32'h100; pc_enable_hbu = 1'b0;
    tick();
    chk("brst_rom", rom_a, 32'h44); chk("brst_flush", {16'b0, fl_a}, 32'h1);
    pc_enable_hbu = 1'b1;
    tick();
    chk("brrel_rom", rom_a, 32'h100); chk("brrel_flush", {16'b0, fl_a}, 32'h2);

    // 5a. Misaligned target.
    branch_target = 32'h43;
    tick(); tick();
    chk("mis_rom", rom_a, 32'h40);
    branch_taken = 1'b0;

    // Global enable low freezes everything.
    pc_enable = 1'b0;
    tick();
    chk("pcen_rom", rom_a, 32'h40);
    pc_enable = 1'b1;
    tick();

    // 6. Reset coincident with a live redirect.
    branch_taken = 1'b1; branch_target = 32'h80; p_rst_s = 1'b1;
    tick();
    chk("rstbr_rom", rom_a, 32'h0); chk("rstbr_flush", {16'b0, fl_a}, 32'h0);
    chk("rstbr_valid", {31'b0, vld_a}, 32'h0);
    p_rst_s = 1'b0; branch_taken = 1'b0;
    tick();
    chk("rstbr_fetch_instr", iid_a, 32'hA000_0000);

    // Counter saturation on the 3-bit instance.
    for (int k = 0; k < 9; k++) tick();
    chk("sat_a_fetch", {16'b0, fcnt_a}, 32'd10);
    chk("sat_c_fetch", {29'b0, fcnt_c}, 32'd7);

    // Randomized phase.
    for (int k = 0; k < 600; k++) begin
      p_rst_s       = ($urandom_range(0, 99) < 2);
      pc_enable     = ($urandom_range(0, 9) != 0);
      pc_enable_hbu = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 9) < 3);
      branch_target = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
